// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg : shared types and width helpers for the sequential Booth multiplier
// Revision  : 1.0
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold WIDTH+1, the number of Booth steps per operation.
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic int acc_w(input int width);
        return width + 2;
    endfunction

    function automatic int q_w(input int width);
        return width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// booth_step : one radix-2 Booth add/subtract followed by an arithmetic shift
// Revision   : 1.0
// ============================================================================
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [acc_w(WIDTH)-1:0] acc_i,
    input  logic [q_w(WIDTH)-1:0]   q_i,
    input  logic                    q1_i,
    input  logic [acc_w(WIDTH)-1:0] m_i,
    output logic [acc_w(WIDTH)-1:0] acc_o,
    output logic [q_w(WIDTH)-1:0]   q_o,
    output logic                    q1_o
);

    localparam int ACC_W = acc_w(WIDTH);
    localparam int Q_W   = q_w(WIDTH);

    logic [ACC_W-1:0] w_sum;

    always_comb begin
        w_sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   w_sum = acc_i + m_i;
            2'b10:   w_sum = acc_i - m_i;
            default: w_sum = acc_i;
        endcase
    end

    // Shift {ACC,Q,q_1} right by one, replicating the ACC sign bit.
    assign acc_o = {w_sum[ACC_W-1], w_sum[ACC_W-1:1]};
    assign q_o   = {w_sum[0], q_i[Q_W-1:1]};
    assign q1_o  = q_i[0];

endmodule
`default_nettype wire

// File: rtl/booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// booth_multiplier_seq : iterative radix-2 Booth multiplier, signed/unsigned,
//                        valid/ready on input and output
// Revision             : 1.0
// ============================================================================
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam int ACC_W = acc_w(WIDTH);
    localparam int Q_W   = q_w(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH + 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [Q_W-1:0]     q_q;
    logic               q1_q;
    logic [ACC_W-1:0]   m_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;

    logic [ACC_W-1:0]   w_acc_nxt;
    logic [Q_W-1:0]     w_q_nxt;
    logic               w_q1_nxt;
    logic [Q_W-1:0]     w_a_ext;
    logic [Q_W-1:0]     w_b_ext;
    logic               w_accept;
    logic               w_steps_done;

    // One extra operand bit lets the same signed datapath serve unsigned mode.
    assign w_a_ext      = {is_signed & a[WIDTH-1], a};
    assign w_b_ext      = {is_signed & b[WIDTH-1], b};
    assign w_accept     = in_valid && (state_q == IDLE);
    assign w_steps_done = (cnt_q == C_LAST_CNT);

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (w_acc_nxt),
        .q_o   (w_q_nxt),
        .q1_o  (w_q1_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (w_steps_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (w_accept) begin
            acc_q <= '0;
            q_q   <= w_a_ext;
            q1_q  <= 1'b0;
            m_q   <= {w_b_ext[Q_W-1], w_b_ext};
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            if (w_steps_done) begin
                product_q <= {acc_q[WIDTH-2:0], q_q};
            end else begin
                acc_q <= w_acc_nxt;
                q_q   <= w_q_nxt;
                q1_q  <= w_q1_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier_seq.sv
`default_nettype none
// ============================================================================
// tb_booth_multiplier_seq : directed-vector scoreboard bench, WIDTH=8
// Revision                : 1.0
// ============================================================================
module tb_booth_multiplier_seq;

    localparam int WIDTH = 8;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b1;
    logic               is_signed = 1'b0;
    logic [WIDTH-1:0]   a         = '0;
    logic [WIDTH-1:0]   b         = '0;
    logic               in_ready;
    logic               out_valid;
    logic               busy;
    logic [2*WIDTH-1:0] product;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [15:0]        exp_q[$];
    logic [15:0]        mon_exp;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        vs;
        logic [15:0] ve;
    } vec_t;

    vec_t vecs[11] = '{
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},   // 255*255 unsigned
        '{8'hFF, 8'hFF, 1'b1, 16'h0001},   // -1*-1
        '{8'h07, 8'hFD, 1'b1, 16'hFFEB},   // 7*-3
        '{8'h00, 8'hC8, 1'b0, 16'h0000},   // 0*200
        '{8'h7F, 8'h80, 1'b1, 16'hC080},   // 127*-128
        '{8'h80, 8'h02, 1'b0, 16'h0100},   // 128*2 unsigned
        '{8'h80, 8'h01, 1'b1, 16'hFF80},   // -128*1
        '{8'h80, 8'h80, 1'b0, 16'h4000},   // 128*128 unsigned
        '{8'hC8, 8'h03, 1'b0, 16'h0258},   // 200*3
        '{8'hFF, 8'h7F, 1'b1, 16'hFF81},   // -1*127
        '{8'h05, 8'h00, 1'b1, 16'h0000}    // 5*0
    };

    booth_multiplier_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out or unexpected event", name);
    endtask

    // Scoreboard monitor: every output handshake consumes one expected product.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                mon_exp = exp_q.pop_front();
                check("product", {16'h0, product}, {16'h0, mon_exp});
            end
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                         input logic [15:0] e, input bit expect_out);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) fail_now("issue_wait");
        a         = ia;
        b         = ib;
        is_signed = is;
        in_valid  = 1'b1;
        if (expect_out) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    initial begin
        int lat;
        int guard;

        repeat (3) @(negedge clk);
        check("reset_in_ready",  {31'h0, in_ready},  32'h1);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_busy",      {31'h0, busy},      32'h0);
        check("reset_product",   {16'h0, product},   32'h0);
        rst_n = 1'b1;

        // Most-negative squared, with exact latency measurement.
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 10);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].ve, 1'b1);
        end
        drain();

        // Output stall: result must hold while in_valid pulses are ignored.
        out_ready = 1'b0;
        issue(8'h0F, 8'h11, 1'b0, 16'h00FF, 1'b1);
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) fail_now("stall_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_product",   {16'h0, product},   32'h00FF);
            check("stall_out_valid", {31'h0, out_valid}, 32'h1);
            check("stall_in_ready",  {31'h0, in_ready},  32'h0);
            check("stall_busy",      {31'h0, busy},      32'h1);
            a         = 8'hAA;
            b         = 8'h55;
            is_signed = 1'b1;
            in_valid  = (i % 2 == 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of CALC aborts the operation.
        issue(8'h64, 8'h64, 1'b0, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        check("abort_busy",      {31'h0, busy},      32'h0);
        check("abort_product",   {16'h0, product},   32'h0);
        check("abort_in_ready",  {31'h0, in_ready},  32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'h07, 8'hFD, 1'b1, 16'hFFEB, 1'b1);
        drain();

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
